alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Adds a start/done handshake, registered results and flags, a carry-out flag, a precision-correct average and an iterative multi-cycle signed multiply.
- Sits between the datapath register file and the controller FSM.
- The controller issues one operation at a time and samples `outW`/flags on `done`.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- CNTW, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rstN  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- opc  input  4  opcode, sampled with start.
- inA  input  WIDTH  signed operand A, sampled with start.
- inB  input  WIDTH  signed operand B, sampled with start.
- inC  input  1  carry-in for ADDC, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when outW/flags update.
- outW  output  WIDTH  signed result, held until next done.
- zer  output  1  outW == 0.
- neg  output  1  outW[WIDTH-1].
- cout  output  1  unsigned carry-out (ADDC, INC only).

Behaviour:
- Reset (rstN low, asynchronous, any state): state=IDLE; busy=0, done=0, outW=0, zer=0, neg=0, cout=0; multiply counter and accumulators cleared. An operation in flight is abandoned; no done is produced for it.
- States:
  - IDLE: on start, latch opc/inA/inB/inC. MUL goes to MULT; all other opcodes go to FIN.
  - FIN: register result and flags; done=1 for this cycle; go to IDLE.
  - MULT: one shift-add step per cycle for WIDTH cycles, then go to FIN.
- Latency (start edge to done high):
  - Single-cycle ops: done asserted 1 cycle after start is sampled.
  - MUL: done asserted WIDTH+1 cycles after start is sampled.
- busy=1 in MULT and FIN; busy=0 in IDLE.
- start while busy=1 is ignored, not queued. start in the same cycle done is high is also ignored; the earliest new start is sampled the cycle after done.
- Opcodes. Arithmetic is WIDTH-bit two's complement, wrapping.
  - 0000 NEG: ~A+1.
  - 0001 INC: A+1; cout = carry out of the unsigned W-bit add.
  - 0010 ADDC: A+B+inC; cout = carry out of the unsigned add.
  - 0011 AVG: (A+B)>>>1, computed in WIDTH+1 signed bits, so it never overflows. Example: 0x7FFF avg 0x7FFF = 0x7FFF.
  - 0100 AND, 0101 OR, 0110 XOR.
  - 0111 PASSB: result B.
  - 1000 MUL: low WIDTH bits of the signed product A*B, computed by iterative shift-add over WIDTH cycles.
  - 1001–1111: result 0, zer=1, single-cycle.
- Flags: zer, neg and cout update only on done, together with outW. cout=0 for every opcode except INC/ADDC.
- Outputs are stable between done pulses. done is never asserted two consecutive cycles.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: adds output port ovf (1 bit), updated with done, reset to 0.
  - NEG: ovf=1 iff A == most-negative value.
  - INC/ADDC: ovf=1 on signed overflow.
  - MUL: ovf=1 iff the full 2*WIDTH product does not sign-fit in WIDTH bits.
  - Others: ovf=0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16):
- Reset: rstN=0 mid-MUL (cycle 5 of MULT) → all outputs 0 asynchronously; after release, busy=0 and no done pulse.
- ADDC A=0xFFFF, B=0x0001, inC=1 → 1 cycle later done=1, outW=0x0001, cout=1, zer=0, neg=0.
- AVG A=0x7FFF, B=0x7FFF → outW=0x7FFF, neg=0. AVG A=0x8000, B=0xFFFF → outW=0xBFFF (-16385), neg=1.
- MUL A=-3 (0xFFFD), B=7 → busy high 17 cycles, done on cycle 17, outW=0xFFEB (-21), neg=1. A second start at cycle 3 is ignored.
- NEG A=0x0000 → outW=0, zer=1. Opcode 1010 → outW=0, zer=1, done after 1 cycle.
- With ALU_OVF_EN: INC A=0x7FFF → outW=0x8000, ovf=1. MUL A=0x0100, B=0x0100 → outW=0x0000, ovf=1, zer=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a start/done handshake and iterative signed multiply.
// Latency: single-cycle opcodes raise done in the first cycle after start is sampled; MUL raises it in cycle WIDTH+1.
// Backpressure: none queued; start is taken only in IDLE, and is dropped while busy or during the done cycle.
//
// Ports:
//   clk, rstN          rising-edge clock, asynchronous active-low reset
//   start, opc         operation request and 4-bit opcode (sampled together in IDLE)
//   inA, inB, inC      signed operands and ADDC carry-in (sampled with start)
//   busy, done         in-progress indicator, one-cycle completion pulse
//   outW, zer, neg     registered result and its zero/sign flags (held between done pulses)
//   cout               unsigned carry-out, INC/ADDC only
//   ovf                signed overflow flag, present only when ALU_OVF_EN is defined
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [3:0]       opc,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             cout
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int PW = 2 * WIDTH;

  localparam logic [3:0] OP_NEG   = 4'b0000;
  localparam logic [3:0] OP_INC   = 4'b0001;
  localparam logic [3:0] OP_ADDC  = 4'b0010;
  localparam logic [3:0] OP_AVG   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MULT = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_w_q, out_w_d;
  logic               zer_q, zer_d;
  logic               neg_q, neg_d;
  logic               cout_q, cout_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
`ifdef ALU_OVF_EN
  logic               ovf_q, ovf_d;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_hi;
`endif

  // Single-cycle datapath, evaluated straight from the inputs so the result
  // can be registered on the same edge that samples start.
  logic [WIDTH:0]     inc_sum;
  logic [WIDTH:0]     addc_sum;
  logic [WIDTH:0]     avg_sum;
  logic               unused_avg_lsb;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;

  assign inc_sum  = {1'b0, inA} + {{WIDTH{1'b0}}, 1'b1};
  assign addc_sum = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inC};
  // Sign-extend to WIDTH+1 so the sum cannot overflow; dropping bit 0 is the
  // arithmetic shift right by one.
  assign avg_sum  = {inA[WIDTH-1], inA} + {inB[WIDTH-1], inB};
  assign unused_avg_lsb = avg_sum[0];

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    unique case (opc)
      OP_NEG:   alu_res = ~inA + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_INC:   {alu_cout, alu_res} = inc_sum;
      OP_ADDC:  {alu_cout, alu_res} = addc_sum;
      OP_AVG:   alu_res = avg_sum[WIDTH:1];
      OP_AND:   alu_res = inA & inB;
      OP_OR:    alu_res = inA | inB;
      OP_XOR:   alu_res = inA ^ inB;
      OP_PASSB: alu_res = inB;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    alu_ovf = 1'b0;
    unique case (opc)
      OP_NEG:  alu_ovf = (inA == {1'b1, {(WIDTH-1){1'b0}}});
      OP_INC:  alu_ovf = ~inA[WIDTH-1] & inc_sum[WIDTH-1];
      OP_ADDC: alu_ovf = (inA[WIDTH-1] == inB[WIDTH-1]) &&
                         (addc_sum[WIDTH-1] != inA[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // One shift-add step. Bit WIDTH-1 of a two's-complement multiplier carries
  // negative weight, so the final step subtracts instead of adding.
  logic            mul_last;
  logic [PW-1:0]   mul_acc;

  assign mul_last = (cnt_q == CNTW'(WIDTH - 1));

  always_comb begin
    mul_acc = acc_q;
    if (mplier_q[0]) begin
      mul_acc = mul_last ? (acc_q - mcand_q) : (acc_q + mcand_q);
    end
  end

`ifdef ALU_OVF_EN
  // The product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
  assign mul_hi = mul_acc[PW-1:WIDTH-1];
`endif

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    out_w_d  = out_w_q;
    zer_d    = zer_q;
    neg_d    = neg_q;
    cout_d   = cout_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opc == OP_MUL) begin
            state_d  = S_MULT;
            acc_d    = '0;
            mcand_d  = {{WIDTH{inA[WIDTH-1]}}, inA};
            mplier_d = inB;
            cnt_d    = '0;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
            out_w_d = alu_res;
            zer_d   = (alu_res == '0);
            neg_d   = alu_res[WIDTH-1];
            cout_d  = alu_cout;
`ifdef ALU_OVF_EN
            ovf_d   = alu_ovf;
`endif
          end
        end
      end
      S_MULT: begin
        acc_d    = mul_acc;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNTW'(1);
        if (mul_last) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          out_w_d = mul_acc[WIDTH-1:0];
          zer_d   = (mul_acc[WIDTH-1:0] == '0);
          neg_d   = mul_acc[WIDTH-1];
          cout_d  = 1'b0;
`ifdef ALU_OVF_EN
          ovf_d   = !((&mul_hi) || (~|mul_hi));
`endif
        end
      end
      S_FIN: begin
        // Result is visible this cycle; any start seen here is dropped.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      out_w_q  <= '0;
      zer_q    <= 1'b0;
      neg_q    <= 1'b0;
      cout_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      out_w_q  <= out_w_d;
      zer_q    <= zer_d;
      neg_q    <= neg_d;
      cout_q   <= cout_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign outW = out_w_q;
  assign zer  = zer_q;
  assign neg  = neg_q;
  assign cout = cout_q;
`ifdef ALU_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=16: expected results come from an integer
// reference model, are queued when an operation is issued and are popped
// when done is observed.
module tb_alu_seq;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [3:0]  opc;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        inC;
  logic        busy;
  logic        done;
  logic [15:0] outW;
  logic        zer;
  logic        neg;
  logic        cout;
  logic        ovf_obs;

  typedef struct packed {
    logic [15:0] w;
    logic        z;
    logic        n;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .opc   (opc),
    .inA   (inA),
    .inB   (inB),
    .inC   (inC),
    .busy  (busy),
    .done  (done),
    .outW  (outW),
    .zer   (zer),
    .neg   (neg),
    .cout  (cout)
`ifdef ALU_OVF_EN
    ,
    .ovf   (ovf_obs)
`endif
  );

`ifndef ALU_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    e  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    case (op)
      4'd0: begin r = -sa; e.o = (a == 16'h8000); end
      4'd1: begin
        r   = sa + 1;
        e.c = (a == 16'hFFFF);
        e.o = (r > 32767);
      end
      4'd2: begin
        r   = sa + sb + int'(c);
        e.c = ((int'(a) + int'(b) + int'(c)) > 65535);
        e.o = (r > 32767) || (r < -32768);
      end
      4'd3: r = (sa + sb) >>> 1;
      4'd4: r = int'(a & b);
      4'd5: r = int'(a | b);
      4'd6: r = int'(a ^ b);
      4'd7: r = int'(b);
      4'd8: begin r = sa * sb; e.o = (r > 32767) || (r < -32768); end
      default: r = 0;
    endcase
    e.w = r[15:0];
    e.z = (e.w == 16'h0000);
    e.n = e.w[15];
`ifndef ALU_OVF_EN
    e.o = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t g;
    g.w = outW;
    g.z = zer;
    g.n = neg;
    g.c = cout;
    g.o = ovf_obs;
    return g;
  endfunction

  // Issues one operation and waits (bounded) for done. lat counts cycles from
  // the sampling edge: 1 means done is high in the first cycle afterwards.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic c,
                        output int lat, output exp_t got);
    @(negedge clk);
    opc = op; inA = a; inB = b; inC = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got = observe();
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t e;
    int   lat;
    int   nd;
    int   nb;
    rstN = 1'b0; start = 1'b0; opc = 4'h0; inA = '0; inB = '0; inC = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, observe()} !== 22'h0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b res=%h want all 0", busy, done, observe());
    end
    rstN = 1'b1;
    // Make the outputs non-zero so the asynchronous clear is visible.
    sb_q.push_back(model(4'd7, 16'h0000, 16'h8001, 1'b0));
    run_op(4'd7, 16'h0000, 16'h8001, 1'b0, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_passb got %h want %h", got, e);
    end
    @(negedge clk);
    opc = 4'd8; inA = 16'h1234; inB = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    total++;
    if ({busy, done, observe()} !== 22'h0) begin
      bad++;
      $display("FAIL reset_async got busy=%b done=%b res=%h want all 0", busy, done, observe());
    end
    @(negedge clk);
    rstN = 1'b1;
    nd = 0; nb = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL reset_no_done got %0d pulses want 0", nd);
    end
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL reset_idle got %0d busy cycles want 0", nb);
    end
  endtask

  task automatic test_addc();
    exp_t got;
    exp_t e;
    int   lat;
    sb_q.push_back(model(4'd2, 16'hFFFF, 16'h0001, 1'b1));
    run_op(4'd2, 16'hFFFF, 16'h0001, 1'b1, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.w !== 16'h0001 || got.c !== 1'b1) begin
      bad++;
      $display("FAIL addc_result got %h want %h", got, e);
    end
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL addc_latency got %0d want 1", lat);
    end
  endtask

  task automatic test_avg();
    exp_t got;
    exp_t e;
    int   lat;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [15:0] vw [2];
    va = '{16'h7FFF, 16'h8000};
    vb = '{16'h7FFF, 16'hFFFF};
    vw = '{16'h7FFF, 16'hBFFF};
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(model(4'd3, va[i], vb[i], 1'b0));
      run_op(4'd3, va[i], vb[i], 1'b0, lat, got);
      e = sb_q.pop_front();
      total++;
      if (got !== e || got.w !== vw[i]) begin
        bad++;
        $display("FAIL avg_%0d got %h want %h (outW %h)", i, got, e, vw[i]);
      end
    end
  endtask

  task automatic test_mul();
    exp_t got;
    exp_t e;
    int   nb;
    int   nd;
    int   dcyc;
    got = '0; nb = 0; nd = 0; dcyc = 0;
    sb_q.push_back(model(4'd8, 16'hFFFD, 16'h0007, 1'b0));
    @(negedge clk);
    opc = 4'd8; inA = 16'hFFFD; inB = 16'h0007; inC = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        dcyc = cyc;
        got = observe();
      end
      // Second request mid-multiply must be dropped, not queued.
      if (cyc == 3) begin
        start = 1'b1; opc = 4'd7; inB = 16'h1234;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.w !== 16'hFFEB) begin
      bad++;
      $display("FAIL mul_result got %h want %h", got, e);
    end
    total++;
    if (nb !== 17) begin
      bad++;
      $display("FAIL mul_busy got %0d cycles want 17", nb);
    end
    total++;
    if (nd !== 1) begin
      bad++;
      $display("FAIL mul_done_count got %0d want 1", nd);
    end
    total++;
    if (dcyc !== 17) begin
      bad++;
      $display("FAIL mul_latency got %0d want 17", dcyc);
    end
  endtask

  task automatic test_misc();
    exp_t got;
    exp_t e;
    int   lat;
    int   nd;
    sb_q.push_back(model(4'd0, 16'h0000, 16'h0000, 1'b0));
    run_op(4'd0, 16'h0000, 16'h0000, 1'b0, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.z !== 1'b1) begin
      bad++;
      $display("FAIL neg_zero got %h want %h", got, e);
    end
    sb_q.push_back(model(4'b1010, 16'h0055, 16'h0066, 1'b1));
    run_op(4'b1010, 16'h0055, 16'h0066, 1'b1, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.z !== 1'b1) begin
      bad++;
      $display("FAIL opc1010 got %h want %h", got, e);
    end
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL opc1010_latency got %0d want 1", lat);
    end
    // A start held only during the done cycle must be ignored.
    sb_q.push_back(model(4'd7, 16'h0000, 16'h00AA, 1'b0));
    run_op(4'd7, 16'h0000, 16'h00AA, 1'b0, lat, got);
    e = sb_q.pop_front();
    start = 1'b1; opc = 4'd1; inA = 16'h0005;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL start_in_done got %0d pulses want 0", nd);
    end
    total++;
    if (observe() !== e) begin
      bad++;
      $display("FAIL hold_after_done got %h want %h", observe(), e);
    end
  endtask

  task automatic test_ovf();
    exp_t got;
    exp_t e;
    int   lat;
    sb_q.push_back(model(4'd1, 16'h7FFF, 16'h0000, 1'b0));
    run_op(4'd1, 16'h7FFF, 16'h0000, 1'b0, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.w !== 16'h8000) begin
      bad++;
      $display("FAIL inc_max got %h want %h", got, e);
    end
    sb_q.push_back(model(4'd8, 16'h0100, 16'h0100, 1'b0));
    run_op(4'd8, 16'h0100, 16'h0100, 1'b0, lat, got);
    e = sb_q.pop_front();
    total++;
    if (got !== e || got.z !== 1'b1) begin
      bad++;
      $display("FAIL mul_wrap got %h want %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        got;
    exp_t        e;
    int          lat;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] edge_v [6];
    edge_v = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 4 == 0) op = 4'd8;
      a = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : 16'($urandom);
      c = 1'($urandom_range(0, 1));
      sb_q.push_back(model(op, a, b, c));
      run_op(op, a, b, c, lat, got);
      e = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL b2b_%0d op=%h a=%h b=%h c=%b got %h want %h", i, op, a, b, c, got, e);
      end
      total++;
      if (lat !== ((op == 4'd8) ? 17 : 1)) begin
        bad++;
        $display("FAIL b2b_lat_%0d op=%h got %0d want %0d", i, op, lat, (op == 4'd8) ? 17 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addc();
    test_avg();
    test_mul();
    test_misc();
    test_ovf();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
